// File: rtl/fifo_1rw_mem_ctrl_if.sv
// fifo_1rw_mem_ctrl_if: producer, consumer and single-port RAM pins of the FIFO controller.
interface fifo_1rw_mem_ctrl_if #(
  parameter int width_p = 8,
  parameter int els_p = 16
);
  localparam int addr_width_lp = $clog2(els_p);
  logic                     v_i;
  logic [width_p-1:0]       data_i;
  logic                     ready_o;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic                     yumi_i;
  logic                     mem_v_o;
  logic                     mem_w_o;
  logic [addr_width_lp-1:0] mem_addr_o;
  logic [width_p-1:0]       mem_data_o;
  logic [width_p-1:0]       mem_data_i;
  modport slave (
    input  v_i, data_i, yumi_i, mem_data_i,
    output ready_o, v_o, data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o
  );
  modport master (
    output v_i, data_i, yumi_i, mem_data_i,
    input  ready_o, v_o, data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/fifo_1rw_mem_ctrl.sv
// fifo_1rw_mem_ctrl: FIFO over a 1-port sync RAM, with a 2-entry output buffer
// and an empty-RAM bypass hiding the one-cycle read latency.
module fifo_1rw_mem_ctrl #(
  parameter int width_p = 8,
  parameter int els_p = 16
) (
  input logic clk_i,
  input logic reset_n_i,
  fifo_1rw_mem_ctrl_if.slave bus
);
  localparam int addr_width_lp = $clog2(els_p);
  localparam int cw_lp = addr_width_lp + 1;
  logic [addr_width_lp-1:0] r_wr_ptr, r_rd_ptr;
  logic [cw_lp-1:0]         r_mem_cnt;
  logic                     r_rd_pend;
  logic [1:0]               r_out_cnt;
  logic [width_p-1:0]       r_buf_0, r_buf_1;
  logic                     w_rd_issue, w_bypass, w_ready, w_acc, w_wr, w_push;
  logic [width_p-1:0]       w_push_d;
  // Reads never wait on yumi_i, so memory and ready outputs stay free of it.
  assign w_rd_issue = (r_mem_cnt != '0) && ((r_out_cnt + 2'(r_rd_pend)) < 2'd2);
  assign w_bypass   = (r_mem_cnt == '0) && !r_rd_pend && (r_out_cnt < 2'd2);
  assign w_ready    = reset_n_i && (w_bypass || ((r_mem_cnt < cw_lp'(els_p)) && !w_rd_issue));
  assign w_acc      = bus.v_i && w_ready;
  assign w_wr       = w_acc && !w_bypass;
  assign w_push     = r_rd_pend || (w_acc && w_bypass);
  assign w_push_d   = r_rd_pend ? bus.mem_data_i : bus.data_i;
  assign bus.ready_o    = w_ready;
  assign bus.v_o        = r_out_cnt != 2'd0;
  assign bus.data_o     = r_buf_0;
  assign bus.mem_v_o    = w_rd_issue || w_wr;
  assign bus.mem_w_o    = w_wr;
  assign bus.mem_addr_o = w_wr ? r_wr_ptr : r_rd_ptr;
  assign bus.mem_data_o = bus.data_i;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_rd_pend <= 1'b0;
      r_out_cnt <= 2'd0;
      r_buf_0   <= '0;
      r_buf_1   <= '0;
    end else begin
      r_wr_ptr  <= w_wr ? r_wr_ptr + addr_width_lp'(1) : r_wr_ptr;
      r_rd_ptr  <= w_rd_issue ? r_rd_ptr + addr_width_lp'(1) : r_rd_ptr;
      r_mem_cnt <= r_mem_cnt + cw_lp'(w_wr) - cw_lp'(w_rd_issue);
      r_rd_pend <= w_rd_issue;
      r_out_cnt <= r_out_cnt + 2'(w_push) - 2'(bus.yumi_i);
      // Pop shifts the head first; a push then lands in the first free slot.
      r_buf_0   <= bus.yumi_i ? (r_out_cnt[1] ? r_buf_1 : w_push_d)
                              : ((w_push && r_out_cnt == 2'd0) ? w_push_d : r_buf_0);
      r_buf_1   <= (w_push && (r_out_cnt - 2'(bus.yumi_i)) == 2'd1) ? w_push_d : r_buf_1;
    end
  end
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) bus.yumi_i |-> bus.v_o);
endmodule

// File: tb/tb_fifo_1rw_mem_ctrl.sv
// tb_fifo_1rw_mem_ctrl: vector table, corner sequences and random traffic
// checked against a scoreboard queue and a behavioural RAM.
module tb_fifo_1rw_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fifo_1rw_mem_ctrl_if #(.width_p(8), .els_p(16)) bus ();
  fifo_1rw_mem_ctrl #(.width_p(8), .els_p(16)) dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus));
  logic [7:0] ram [16];
  always @(posedge clk)
    if (bus.mem_v_o) begin
      if (bus.mem_w_o) ram[bus.mem_addr_o] <= bus.mem_data_o;
      else bus.mem_data_i <= ram[bus.mem_addr_o];
    end
  typedef struct {
    logic v; logic [7:0] d; logic y;
    logic rdy; logic mv; logic vo; logic [7:0] dout;
  } vec_t;
  vec_t tbl [10];
  logic [7:0] sb [$];
  int errors = 0, checks = 0, acc_cnt = 0;
  logic [3:0] exp_wa, exp_ra;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Called half a cycle before the edge that will act on the current inputs.
  task automatic mon();
    chk("occupancy_le_18", 32'(sb.size() <= 18), 1);
    if (sb.size() == 18) chk("ready_when_full", 32'(bus.ready_o), 0);
    if (bus.v_o && bus.yumi_i) begin
      chk("sb_nonempty_on_pop", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        chk("data_o", 32'(bus.data_o), 32'(sb[0]));
        void'(sb.pop_front());
      end
    end
    if (bus.mem_v_o && bus.mem_w_o) begin
      chk("wr_addr", 32'(bus.mem_addr_o), 32'(exp_wa));
      chk("wr_data", 32'(bus.mem_data_o), 32'(bus.data_i));
      chk("wr_accepted", 32'(bus.v_i && bus.ready_o), 1);
      exp_wa++;
    end
    if (bus.mem_v_o && !bus.mem_w_o) begin
      chk("rd_addr", 32'(bus.mem_addr_o), 32'(exp_ra));
      exp_ra++;
    end
    if (bus.v_i && bus.ready_o) begin
      sb.push_back(bus.data_i);
      acc_cnt++;
    end
  endtask
  task automatic cyc(input logic v, input logic [7:0] d, input logic y);
    @(negedge clk);
    bus.v_i = v;
    bus.data_i = d;
    bus.yumi_i = y && bus.v_o;
    #1;
    mon();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.v_i = 1'b0;
    bus.yumi_i = 1'b0;
    sb.delete();
    exp_wa = '0;
    exp_ra = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic fill(input logic [7:0] base);
    acc_cnt = 0;
    for (int k = 0; k < 100 && acc_cnt < 18; k++) cyc(1'b1, base + 8'(acc_cnt), 1'b0);
    chk("fill_count", 32'(acc_cnt), 18);
  endtask
  task automatic drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++) cyc(1'b0, 8'h00, 1'b1);
    chk("drained", 32'(sb.size()), 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("v_o_after_drain", 32'(bus.v_o), 0);
  endtask
  initial begin
    bus.v_i = 1'b0; bus.data_i = '0; bus.yumi_i = 1'b0; bus.mem_data_i = '0;
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[3] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[4] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].y);
      chk($sformatf("vec%0d_ready", i), 32'(bus.ready_o), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_mem_v", i), 32'(bus.mem_v_o), 32'(tbl[i].mv));
      chk($sformatf("vec%0d_v_o", i), 32'(bus.v_o), 32'(tbl[i].vo));
      if (tbl[i].vo) chk($sformatf("vec%0d_data_o", i), 32'(bus.data_o), 32'(tbl[i].dout));
    end
    // Reset in the middle of a stream drops everything.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.v_i = 1'b0;
    #1;
    chk("rst_mid_v_o", 32'(bus.v_o), 0);
    chk("rst_mid_ready", 32'(bus.ready_o), 0);
    chk("rst_mid_mem_v", 32'(bus.mem_v_o), 0);
    sb.delete(); exp_wa = '0; exp_ra = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_v_o", 32'(bus.v_o), 0);
    chk("rst_rel_ready", 32'(bus.ready_o), 1);
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("post_rst_v_o", 32'(bus.v_o), 1);
    chk("post_rst_data", 32'(bus.data_o), 32'h77);
    drain();
    // Fill to capacity, then drain through the wrapping read pointer.
    do_reset();
    fill(8'h00);
    cyc(1'b1, 8'h12, 1'b0);
    chk("full_ready", 32'(bus.ready_o), 0);
    chk("full_v_o", 32'(bus.v_o), 1);
    chk("full_head", 32'(bus.data_o), 32'h00);
    drain();
    // Keep the RAM backlogged while both pointers wrap repeatedly.
    do_reset();
    fill(8'h40);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      acc_cnt = 0;
      for (int k = 0; k < 10 && acc_cnt == 0; k++) cyc(1'b1, 8'h80 + 8'(i), 1'b0);
      chk($sformatf("wrap%0d_accepted", i), 32'(acc_cnt), 1);
    end
    drain();
    do_reset();
    for (int i = 0; i < 2000; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
